// File: rtl/line_sample_plotter.sv
// line_sample_plotter: ping-pong column buffer that plots a line-sample trace on the VGA active area
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   sample_data    unsigned sample, accepted when sample_valid && sample_ready
//   sample_valid   sample_data is valid this cycle
//   sample_ready   registered; high while the back bank is filling
//   frame_start    one-cycle pulse at the start of each VGA frame
//   video_active   current pixel lies inside the active area
//   pixel_x/y      current column / row from the VGA timing counters
//   pixel_on       registered plot pixel (1 clk latency)
//   swap_pulse     one-cycle pulse when the back bank becomes the front bank
// Optional: define LINE_SAMPLE_PLOTTER_THICK_EN for a 3-row-thick trace.
module line_sample_plotter #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int DATA_W      = 16,
    parameter int SCALE_SHIFT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              sample_valid,
    output logic              sample_ready,
    input  logic              frame_start,
    input  logic              video_active,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    output logic              pixel_on,
    output logic              swap_pulse
);
    typedef enum logic {FILL, FULL} state_t;
    state_t            state;
    logic [9:0]        write_idx;
    logic              bank_sel;
    logic              front_valid;
    logic [9:0]        mem [2][H_ACTIVE];
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] clamped;
    logic [9:0]        row;
    logic              xfer;
    logic              x_in;
    logic [9:0]        rd;
    logic              hit;

    always_comb begin
        shifted = sample_data >> SCALE_SHIFT;
        clamped = shifted >= DATA_W'(V_ACTIVE) ? DATA_W'(V_ACTIVE - 1) : shifted;
        // Invert so larger samples land on smaller row numbers (higher on screen).
        row     = 10'(DATA_W'(V_ACTIVE - 1) - clamped);
        xfer    = sample_valid && sample_ready && state == FILL;
        x_in    = pixel_x < 10'(H_ACTIVE);
        // Out-of-range columns read entry 0; the result is masked by x_in anyway.
        rd      = mem[bank_sel][x_in ? pixel_x : '0];
`ifdef LINE_SAMPLE_PLOTTER_THICK_EN
        // 11-bit compares so row 0 / the last row never wrap onto a neighbour.
        hit     = rd == pixel_y || {1'b0, rd} == {1'b0, pixel_y} + 11'd1
                  || {1'b0, rd} + 11'd1 == {1'b0, pixel_y};
`else
        hit     = rd == pixel_y;
`endif
    end

    // Only the back bank is ever written, so the displayed bank is stable all frame.
    always_ff @(posedge clk) begin
        if (!rst && xfer)
            mem[~bank_sel][write_idx] <= row;
    end

    always_ff @(posedge clk) begin
        swap_pulse <= 1'b0;
        pixel_on   <= !rst && video_active && front_valid && x_in && hit;
        if (rst) begin
            state        <= FILL;
            write_idx    <= '0;
            bank_sel     <= 1'b0;
            front_valid  <= 1'b0;
            sample_ready <= 1'b0;
        end else if (state == FILL) begin
            sample_ready <= 1'b1;
            if (xfer) begin
                if (write_idx == 10'(H_ACTIVE - 1)) begin
                    state        <= FULL;
                    write_idx    <= '0;
                    sample_ready <= 1'b0;
                end else begin
                    write_idx <= write_idx + 10'd1;
                end
            end
        end else begin
            sample_ready <= 1'b0;
            if (frame_start) begin
                bank_sel     <= ~bank_sel;
                front_valid  <= 1'b1;
                swap_pulse   <= 1'b1;
                state        <= FILL;
                sample_ready <= 1'b1;
            end
        end
    end
endmodule

// File: doc/line_sample_plotter.md
Name: line_sample_plotter

Overview:
- Consumer end of the line-sample stream. Accepts one sample per pixel column from a ramp or straight-line source.
- Stores one display line's worth of samples in a ping-pong column buffer.
- Driven by the VGA timing counters, it outputs a 1-bit pixel_on that draws the sample trace as a plot on the active display area.
- Sits between the sample source and the VGA colour mux.

Parameters:
- H_ACTIVE, 640, number of columns (samples per frame) and buffer depth per bank
- V_ACTIVE, 480, number of active rows; plot row range is 0..V_ACTIVE-1
- DATA_W, 16, sample width
- SCALE_SHIFT, 1, right-shift applied to each sample before plotting (680>>1 = 340)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- sample_data  in  DATA_W  unsigned sample value
- sample_valid  in  1  sample_data is valid this cycle
- sample_ready  out  1  plotter can accept a sample this cycle
- frame_start  in  1  one-cycle pulse at the start of each VGA frame (before first active pixel)
- video_active  in  1  current pixel is inside the active area
- pixel_x  in  10  current column
- pixel_y  in  10  current row
- pixel_on  out  1  registered plot pixel, 1 = draw trace colour
- swap_pulse  out  1  one-cycle pulse when the back bank becomes the front bank

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to FILL; write_idx=0; bank_sel=0; front_valid=0.
  - pixel_on=0; swap_pulse=0; sample_ready=0 while rst is high.
  - Buffer contents are not cleared.
- Storage: two banks of H_ACTIVE entries, each 10 bits wide.
  - front bank = bank_sel.
  - back bank = ~bank_sel.
- Scaling on write:
  - s = sample_data >> SCALE_SHIFT.
  - If s >= V_ACTIVE, clamp to V_ACTIVE-1.
  - Stored row = V_ACTIVE-1-s, so larger values plot higher on screen.
- Handshake:
  - A transfer occurs on an edge where sample_valid && sample_ready.
  - sample_ready is a registered output: 1 in FILL, 0 in FULL and during reset.
  - sample_data is ignored when no transfer occurs.
- State FILL:
  - Each transfer writes back[write_idx] and increments write_idx.
  - The transfer with write_idx==H_ACTIVE-1 moves the state to FULL with write_idx=0, and sample_ready drops on the same edge.
  - frame_start while in FILL is ignored: no swap, and filling continues.
  - If frame_start coincides with the final transfer, no swap occurs that frame.
- State FULL:
  - No transfers are accepted.
  - On frame_start: bank_sel toggles, front_valid=1, swap_pulse=1 for exactly one cycle, and state returns to FILL (sample_ready=1 next cycle).
- Display read path:
  - pixel_on is registered from the current-cycle inputs, so latency is 1 clk.
  - pixel_on = video_active && front_valid && pixel_x<H_ACTIVE && front[pixel_x]==pixel_y.
  - pixel_x >= H_ACTIVE gives 0 with no out-of-range read.
  - The front bank is never written while it is front, so display data is stable for the whole frame.
- Reset mid-fill: partial back-bank data is discarded logically because write_idx=0. Since front_valid=0, nothing is drawn until the next complete fill and swap.
- All counters are unsigned. write_idx is 10 bits and never exceeds H_ACTIVE-1.

Optional Feature:
- Macro: LINE_SAMPLE_PLOTTER_THICK_EN.
- Defined: the trace is 3 rows thick.
  - pixel_on is also 1 when front[pixel_x]==pixel_y+1 or front[pixel_x]+1==pixel_y, subject to the same active/valid/range gating.
  - There is no wrap at row 0 or V_ACTIVE-1.
- Undefined: single-row trace only, exactly as in Behaviour.

Test Plan:
- Reset checks:
  - Assert rst 3 cycles, then release with sample_valid=1 -> sample_ready=0 during rst and 1 the first cycle after.
  - pixel_on=0 for an entire frame because front_valid=0.
- Full fill, then swap:
  - Stream samples 0..639 (valid held high) -> sample_ready falls after the 640th transfer.
  - Next frame_start -> swap_pulse=1 for 1 cycle.
  - Following frame: pixel_x=100, pixel_y=429 (479-50) -> pixel_on=1 one cycle later.
  - Same pixel_x with pixel_y=430 -> pixel_on=0.
- Clamp:
  - Sample value 2000 at column 5 -> stored row 0.
  - pixel_x=5, pixel_y=0, video_active=1 -> pixel_on=1.
- Frame_start during FILL and coincident with the final transfer:
  - Pulse frame_start after 300 transfers -> no swap_pulse; filling continues.
  - Pulse frame_start on the edge of transfer 640 -> no swap; swap occurs on the following frame_start.
- Gating:
  - After a valid swap, video_active=0 at a matching (x,y) -> pixel_on=0.
  - pixel_x=700 -> pixel_on=0.
- Reset mid-fill:
  - Assert rst after 200 transfers -> write_idx restarts at 0.
  - 640 further transfers are needed before FULL; no swap_pulse before that.
  - (THICK build) After the swap, matching row ±1 -> pixel_on=1; ±2 -> pixel_on=0.
